// File: rtl/axi_slave_packer.sv
// axi_slave_packer: AXI read-only slave that streams one SRAM row per fetch
// as packed R beats, in either int32 or int8 (truncated) element format.
// Build option: define AXI_PACKER_ERR_CHECK_EN to answer non-INCR or
// non-8-byte bursts with SLVERR beats and no SRAM access.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cfg_data_type_is_int32    element format, latched at AR handshake
//   ar*                       AXI read-address channel (slave side)
//   r*                        AXI read-data channel (slave side)
//   host_rd_addr/en/data      SRAM row read port, data one cycle after en
module axi_slave_packer #(
    parameter int AXI_DATA_WIDTH  = 64,
    parameter int SRAM_DATA_WIDTH = 32,
    parameter int ARRAY_WIDTH     = 16,
    parameter int ADDR_WIDTH      = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_data_type_is_int32,
    input  logic [31:0]                 araddr,
    input  logic [7:0]                  arlen,
    input  logic [2:0]                  arsize,
    input  logic [1:0]                  arburst,
    input  logic                        arvalid,
    output logic                        arready,
    output logic [AXI_DATA_WIDTH-1:0]   rdata,
    output logic [1:0]                  rresp,
    output logic                        rlast,
    output logic                        rvalid,
    input  logic                        rready,
    output logic [ADDR_WIDTH-1:0]       host_rd_addr,
    output logic                        host_rd_en,
    input  logic [ARRAY_WIDTH-1:0][SRAM_DATA_WIDTH-1:0] host_rd_data
);

    // Elements per beat and beats per row for each format.
    localparam int EPB32 = AXI_DATA_WIDTH / SRAM_DATA_WIDTH;
    localparam int EPB8  = AXI_DATA_WIDTH / 8;
    localparam int BPR32 = ARRAY_WIDTH / EPB32;
    localparam int BPR8  = ARRAY_WIDTH / EPB8;
    localparam int EW    = $clog2(ARRAY_WIDTH);

    typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, SEND} state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] row;
    logic [8:0]            beats_left;
    logic                  mode;
    logic                  err;
    logic [EW-1:0]         beat;
    logic                  row_end;
    logic                  ar_illegal;
    logic [ARRAY_WIDTH-1:0][SRAM_DATA_WIDTH-1:0] rbuf;

`ifdef AXI_PACKER_ERR_CHECK_EN
    assign ar_illegal = (arburst != 2'b01) || (arsize != 3'b011);
`else
    assign ar_illegal = 1'b0;
`endif

    // Address offset bits and (in the default build) burst attributes
    // carry no meaning for this slave.
    logic unused_in;
    assign unused_in = ^{araddr[31:ADDR_WIDTH+6], araddr[5:0],
                         arsize, arburst};

    assign row_end = mode ? (beat == EW'(BPR32 - 1))
                          : (beat == EW'(BPR8 - 1));

    assign host_rd_addr = row;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (arvalid) state_n = ar_illegal ? SEND : RD_REQ;
            RD_REQ:  state_n = RD_WAIT;
            RD_WAIT: state_n = SEND;
            SEND: begin
                if (rready) begin
                    if (beats_left == 9'd1)  state_n = IDLE;
                    else if (!err && row_end) state_n = RD_REQ;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        arready    = (state == IDLE);
        host_rd_en = (state == RD_REQ);
        rvalid     = (state == SEND);
        rdata      = '0;
        rresp      = 2'b00;
        rlast      = 1'b0;
        if (state == SEND) begin
            rlast = (beats_left == 9'd1);
            if (err) begin
                rresp = 2'b10;
            end else if (mode) begin
                for (int j = 0; j < EPB32; j++)
                    rdata[j*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH] =
                        rbuf[EW'(int'(beat) * EPB32 + j)];
            end else begin
                for (int j = 0; j < EPB8; j++)
                    rdata[j*8 +: 8] = rbuf[EW'(int'(beat) * EPB8 + j)][7:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row        <= '0;
            beats_left <= '0;
            mode       <= 1'b0;
            err        <= 1'b0;
            beat       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (arvalid) begin
                        row        <= araddr[ADDR_WIDTH+5:6];
                        beats_left <= {1'b0, arlen} + 9'd1;
                        mode       <= cfg_data_type_is_int32;
                        err        <= ar_illegal;
                        beat       <= '0;
                    end
                end
                RD_WAIT: beat <= '0;
                SEND: begin
                    if (rready) begin
                        beats_left <= beats_left - 9'd1;
                        // Row advance wraps with the address width.
                        if (row_end) begin
                            beat <= '0;
                            row  <= row + ADDR_WIDTH'(1);
                        end else begin
                            beat <= beat + EW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Row buffer holds the fetched SRAM row for the duration of its beats.
    always_ff @(posedge clk) begin
        if (state == RD_WAIT) rbuf <= host_rd_data;
    end

endmodule

// File: tb/tb_axi_slave_packer.sv
// tb_axi_slave_packer: randomized bursts against a row-level reference
// model of the packer, with a one-cycle-latency SRAM model.
module tb_axi_slave_packer;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg;
    logic [31:0]       araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [63:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;
    logic [9:0]        host_rd_addr;
    logic              host_rd_en;
    logic [15:0][31:0] host_rd_data;

    axi_slave_packer dut (
        .clk                    (clk),
        .rst                    (rst),
        .cfg_data_type_is_int32 (cfg),
        .araddr                 (araddr),
        .arlen                  (arlen),
        .arsize                 (arsize),
        .arburst                (arburst),
        .arvalid                (arvalid),
        .arready                (arready),
        .rdata                  (rdata),
        .rresp                  (rresp),
        .rlast                  (rlast),
        .rvalid                 (rvalid),
        .rready                 (rready),
        .host_rd_addr           (host_rd_addr),
        .host_rd_en             (host_rd_en),
        .host_rd_data           (host_rd_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0][31:0] mem [1024];
    logic [9:0]        rd_q [$];
    logic              en_s;
    logic [9:0]        addr_s;

    // SRAM: request seen mid-cycle, data presented after the next edge
    // and only for that one cycle; garbage otherwise.
    always @(negedge clk) begin
        en_s   = host_rd_en;
        addr_s = host_rd_addr;
        if (host_rd_en) rd_q.push_back(host_rd_addr);
    end

    always @(posedge clk) begin
        if (en_s) begin
            host_rd_data <= mem[addr_s];
        end else begin
            for (int i = 0; i < 16; i++) host_rd_data[i] <= $urandom;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Beat b of a burst starting at row0, from the element rules.
    function automatic logic [63:0] exp_beat(int row0, int b, bit m32);
        logic [63:0]       d;
        logic [15:0][31:0] e;
        int                r;
        int                k;
        d = '0;
        if (m32) begin
            r = (row0 + b / 8) % 1024;
            k = b % 8;
            e = mem[10'(r)];
            d = {e[4'(2*k+1)], e[4'(2*k)]};
        end else begin
            r = (row0 + b / 2) % 1024;
            k = b % 2;
            e = mem[10'(r)];
            for (int j = 0; j < 8; j++) d[8*j +: 8] = e[4'(8*k+j)][7:0];
        end
        return d;
    endfunction

    task automatic send_ar(input logic [31:0] addr, input int len,
                           input bit m32, input bit bad);
        int t;
        @(negedge clk);
        araddr  = addr;
        arlen   = 8'(len);
        cfg     = m32;
        arvalid = 1'b1;
`ifdef AXI_PACKER_ERR_CHECK_EN
        arsize  = 3'b011;
        arburst = bad ? 2'b00 : 2'b01;
`else
        arsize  = 3'($urandom);
        arburst = 2'($urandom);
`endif
        t = 0;
        #1;
        while (!arready && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("ar_ready", 64'(arready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        cfg     = ~m32;
        arsize  = 3'($urandom);
        arburst = 2'($urandom);
    endtask

    task automatic run_burst(input logic [31:0] addr, input int len,
                             input bit m32, input bit bad,
                             input int stall_pct, input int hold_after);
        int          n;
        int          bpr;
        int          row0;
        int          nrows;
        int          got;
        int          cyc;
        int          lat;
        int          hold;
        int          stab_bad;
        bit          stalled;
        bit          clash;
        logic [63:0] held;
        logic [63:0] ed;
        n        = len + 1;
        bpr      = m32 ? 8 : 2;
        row0     = int'(addr[15:6]);
        nrows    = bad ? 0 : (n + bpr - 1) / bpr;
        got      = 0;
        cyc      = 0;
        lat      = 0;
        hold     = 0;
        stab_bad = 0;
        stalled  = 0;
        clash    = 0;
        held     = '0;
        rd_q.delete();
        send_ar(addr, len, m32, bad);
        while (got < n && cyc < 2000) begin
            cyc++;
            if (hold > 0) begin
                rready = 1'b0;
                hold--;
            end else begin
                rready = ($urandom_range(99) >= stall_pct);
            end
            #1;
            if (host_rd_en && rvalid) clash = 1;
            if (rvalid && lat == 0) lat = cyc;
            if (stalled && !(rvalid && rdata == held)) stab_bad++;
            if (rvalid && rready) begin
                ed = bad ? 64'd0 : exp_beat(row0, got, m32);
                chk("rdata", rdata, ed);
                chk("rlast", 64'(rlast), 64'(got == n - 1));
                chk("rresp", 64'(rresp), bad ? 64'd2 : 64'd0);
                if (got == hold_after) hold = 5;
                got++;
                stalled = 0;
            end else if (rvalid) begin
                stalled = 1;
                held    = rdata;
            end
            @(negedge clk);
        end
        rready = 1'b0;
        #1;
        chk("beats", 64'(got), 64'(n));
        chk("idle_after", 64'({arready, rvalid}), 64'b10);
        chk("first_lat", 64'(lat), bad ? 64'd1 : 64'd3);
        chk("rd_cnt", 64'(rd_q.size()), 64'(nrows));
        for (int i = 0; i < rd_q.size() && i < nrows; i++)
            chk("rd_addr", 64'(rd_q[i]), 64'((row0 + i) % 1024));
        chk("rd_clash", 64'(clash), 64'd0);
        chk("stable", 64'(stab_bad), 64'd0);
    endtask

    initial begin
        logic [31:0] a;
        int          len;
        int          act;
        rst     = 1'b1;
        cfg     = 1'b0;
        araddr  = '0;
        arlen   = '0;
        arsize  = 3'b011;
        arburst = 2'b01;
        arvalid = 1'b0;
        rready  = 1'b0;
        for (int r = 0; r < 1024; r++)
            for (int i = 0; i < 16; i++) mem[r][i] = $urandom;
        for (int i = 0; i < 16; i++) begin
            mem[0][i] = 32'(i + 1) | 32'hABCD_0000;
            mem[1][i] = 32'(100 + i);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_arready", 64'(arready), 64'd1);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rlast", 64'(rlast), 64'd0);
        chk("rst_rresp", 64'(rresp), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_rd_en", 64'(host_rd_en), 64'd0);
        chk("rst_rd_addr", 64'(host_rd_addr), 64'd0);

        // Directed: int8 row 0, int32 row 1, int8 two rows, backpressure.
        run_burst(32'h0, 1, 0, 0, 0, -1);
        run_burst(32'h40, 7, 1, 0, 0, -1);
        run_burst(32'h80, 3, 0, 0, 30, -1);
        run_burst(32'h40, 7, 1, 0, 0, 2);
        run_burst(32'hFFC0, 9, 0, 0, 20, -1);
        run_burst(32'hFFC0, 11, 1, 0, 20, -1);

        // Reset in the middle of a burst abandons it.
        rd_q.delete();
        send_ar(32'h40, 7, 1, 0);
        rready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("pre_rst_rvalid", 64'(rvalid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_arready", 64'(arready), 64'd1);
        chk("mid_rst_rvalid", 64'(rvalid), 64'd0);
        chk("mid_rst_rdata", rdata, 64'd0);
        chk("mid_rst_rd_addr", 64'(host_rd_addr), 64'd0);
        act = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (host_rd_en || rvalid) act++;
        end
        chk("post_rst_idle", 64'(act), 64'd0);
        chk("post_rst_reads", 64'(rd_q.size()), 64'd1);
        rready = 1'b0;
        run_burst(32'h80, 3, 0, 0, 20, -1);

`ifdef AXI_PACKER_ERR_CHECK_EN
        run_burst(32'h0, 2, 0, 1, 20, -1);
        run_burst(32'h40, 4, 1, 1, 0, -1);
`endif

        for (int t = 0; t < 25; t++) begin
            a = $urandom;
            if (t % 5 == 0) a[15:6] = 10'h3FF;
            len = $urandom_range(0, 40);
            run_burst(a, len, 1'($urandom), 0, $urandom_range(0, 60),
                      ($urandom_range(0, 3) == 0) ?
                          $urandom_range(0, len) : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
